// File: rtl/mem_to_host_packer.sv
// mem_to_host_packer
//   Write-back path from AFU local memory to the host. On a rising edge of start
//   while idle, reads num_lines*16 consecutive words from the memory DMA port,
//   packs each group of 16 words into one cache line and pushes it into the DMA
//   write FIFO.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             level; a rising edge while idle begins a transfer
//   base_addr         word address of the first word (sampled at start)
//   num_lines         number of lines to send (sampled at start)
//   mem_en/mem_wr_en  memory request strobe / write enable (write enable is always 0)
//   mem_addr          word address of the current request
//   mem_rdata         read data, qualified by mem_valid
//   full              DMA write FIFO full
//   wr_data/wr_en     packed line and its one-cycle push strobe
//   busy, done        transfer in progress / transfer finished (held until start low)
module mem_to_host_packer #(
  parameter int unsigned CL_ADDR_WIDTH  = 42,
  parameter int unsigned LINE_WIDTH     = 512,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [CL_ADDR_WIDTH:0]    num_lines,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_valid,
  input  logic                      full,
  output logic [LINE_WIDTH-1:0]     wr_data,
  output logic                      wr_en,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_W          = $clog2(WORDS_PER_LINE);
  localparam int unsigned NL_W           = CL_ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StPush, StDone} state_e;

  state_e                    state_q, state_d;
  logic                      start_q;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [IDX_W-1:0]          word_idx_q, word_idx_d;
  logic [NL_W-1:0]           lines_sent_q, lines_sent_d;
  logic [NL_W-1:0]           num_lines_q, num_lines_d;
  logic [LINE_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      cur_addr_q   <= '0;
      word_idx_q   <= '0;
      lines_sent_q <= '0;
      num_lines_q  <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      cur_addr_q   <= cur_addr_d;
      word_idx_q   <= word_idx_d;
      lines_sent_q <= lines_sent_d;
      num_lines_q  <= num_lines_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    word_idx_d   = word_idx_q;
    lines_sent_d = lines_sent_q;
    num_lines_d  = num_lines_q;
    wr_data_d    = wr_data_q;
    accept       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !start_q) begin
          cur_addr_d   = base_addr;
          num_lines_d  = num_lines;
          lines_sent_d = '0;
          word_idx_d   = '0;
          state_d      = (num_lines == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        // A zero-latency memory answers in the request cycle itself.
        accept  = mem_valid;
        state_d = StWait;
      end
      StWait: begin
        accept = mem_valid;
      end
      StPush: begin
        if (!full) begin
          lines_sent_d = lines_sent_q + NL_W'(1);
          state_d      = (lines_sent_q + NL_W'(1) == num_lines_q) ? StDone : StReq;
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      wr_data_d[word_idx_q*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
      cur_addr_d = cur_addr_q + MEM_ADDR_WIDTH'(1);
      if (word_idx_q == LAST_IDX) begin
        word_idx_d = '0;
        state_d    = StPush;
      end else begin
        word_idx_d = word_idx_q + IDX_W'(1);
        state_d    = StReq;
      end
    end
  end

  assign mem_en    = (state_q == StReq);
  assign mem_wr_en = 1'b0;
  assign mem_addr  = cur_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = (state_q == StPush) && !full;
  assign busy      = (state_q == StReq) || (state_q == StWait) || (state_q == StPush);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_mem_to_host_packer.sv
// Self-checking bench for mem_to_host_packer: a randomized-latency memory responder,
// a monitor logging requests and pushed lines, and a reference model that derives
// each expected line directly from the memory contents at base + 16*line + word.
module tb_mem_to_host_packer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [42:0]  num_lines;
  logic         mem_en;
  logic         mem_wr_en;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_valid;
  logic         full;
  logic [511:0] wr_data;
  logic         wr_en;
  logic         busy;
  logic         done;

  mem_to_host_packer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_lines (num_lines),
    .mem_en    (mem_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .full      (full),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents: mem[a] = (a + mem_off) ^ mem_xor
  logic [31:0] mem_off;
  logic [31:0] mem_xor;
  int          lat_min;
  int          lat_max;

  logic [31:0]  addr_log[$];
  logic [511:0] line_log[$];
  int unsigned  cyc;
  int unsigned  start_cyc;
  int unsigned  done_cyc;
  int unsigned  last_wr_cyc;
  int           memwr_cnt;
  int           overlap_cnt;
  bit           pend;
  int           cnt;
  logic [31:0]  pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a + mem_off) ^ mem_xor;
  endfunction

  function automatic logic [511:0] exp_line(input logic [31:0] b, input int n);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_word(b + 32'(16*n + k));
    return l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder and monitor, evaluated just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      pend      = 1'b0;
      mem_valid = 1'b0;
    end else begin
      mem_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem_word(pend_addr);
          pend      = 1'b0;
        end
      end
      if (mem_en) begin
        if (pend) overlap_cnt++;
        pend      = 1'b1;
        pend_addr = mem_addr;
        cnt       = $urandom_range(lat_max, lat_min);
        addr_log.push_back(mem_addr);
      end
      if (wr_en) begin
        line_log.push_back(wr_data);
        last_wr_cyc = cyc;
      end
      if (mem_wr_en) memwr_cnt++;
    end
  end

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, budget);
    end
  endtask

  task automatic begin_xfer(input logic [31:0] b, input logic [42:0] n,
                            input int lmin, input int lmax);
    addr_log.delete();
    line_log.delete();
    lat_min = lmin;
    lat_max = lmax;
    @(negedge clk);
    base_addr = b;
    num_lines = n;
    start     = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic end_xfer();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_lines(input string name, input logic [31:0] b, input int n);
    int bad_addr = 0;
    checks++;
    if (line_log.size() !== n) begin
      errors++;
      $display("FAIL %s_line_count: got %0d required %0d", name, line_log.size(), n);
    end
    for (int i = 0; i < n && i < line_log.size(); i++) begin
      checks++;
      if (line_log[i] !== exp_line(b, i)) begin
        errors++;
        $display("FAIL %s_line%0d: got %h required %h", name, i, line_log[i], exp_line(b, i));
      end
    end
    checks++;
    if (addr_log.size() !== 16 * n) begin
      errors++;
      $display("FAIL %s_req_count: got %0d required %0d", name, addr_log.size(), 16 * n);
    end
    foreach (addr_log[i]) if (addr_log[i] !== b + 32'(i)) bad_addr++;
    checks++;
    if (bad_addr !== 0) begin
      errors++;
      $display("FAIL %s_addr_seq: %0d bad addresses, required 0", name, bad_addr);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    full      = 1'b0;
    base_addr = '0;
    num_lines = '0;
    mem_rdata = '0;
    mem_valid = 1'b0;
    mem_off   = '0;
    mem_xor   = '0;
    lat_min   = 1;
    lat_max   = 1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({mem_en, mem_wr_en, wr_en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {mem_en, mem_wr_en, wr_en, busy, done});
    end
    checks++;
    if (mem_addr !== 32'h0 || wr_data !== 512'h0) begin
      errors++;
      $display("FAIL reset_data: mem_addr=%h wr_data=%h required 0", mem_addr, wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_line();
    logic [511:0] l;
    logic [31:0]  w;
    mem_off = 32'hFFFF_FF01;  // mem[0x100 + i] = i + 1
    mem_xor = '0;
    begin_xfer(32'h100, 43'd1, 1, 1);
    wait_done(200);
    checks++;
    if (line_log.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d required 1", line_log.size());
    end
    if (line_log.size() > 0) begin
      l = line_log[0];
      w = l[31:0];
      checks++;
      if (w !== 32'd1) begin
        errors++;
        $display("FAIL single_word0: got %h required 1", w);
      end
      w = l[511:480];
      checks++;
      if (w !== 32'd16) begin
        errors++;
        $display("FAIL single_word15: got %h required 16", w);
      end
    end
    checks++;
    if (last_wr_cyc - start_cyc !== 33) begin
      errors++;
      $display("FAIL single_latency: wr_en %0d cycles after start, required 33",
               last_wr_cyc - start_cyc);
    end
    checks++;
    if (done_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL single_done_timing: done at %0d, required %0d", done_cyc, last_wr_cyc + 1);
    end
    check_lines("single", 32'h100, 1);
    end_xfer();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_drop: got %b required 0", done);
    end
  endtask

  task automatic test_random_latency();
    for (int t = 0; t < 2; t++) begin
      logic [31:0] b = $urandom;
      mem_off = $urandom;
      mem_xor = $urandom;
      begin_xfer(b, 43'd3, 1, 5);
      wait_done(2000);
      check_lines("randlat", b, 3);
      end_xfer();
    end
  endtask

  task automatic test_wrap();
    mem_off = $urandom;
    mem_xor = $urandom;
    begin_xfer(32'hFFFF_FFF8, 43'd2, 1, 3);
    wait_done(1000);
    check_lines("wrap", 32'hFFFF_FFF8, 2);
    end_xfer();
  endtask

  task automatic test_full_backpressure();
    logic [31:0]  b = $urandom;
    logic [511:0] snap;
    int           bad = 0;
    int           guard = 0;
    mem_off = $urandom;
    mem_xor = $urandom;
    full    = 1'b1;
    begin_xfer(b, 43'd1, 1, 2);
    while (addr_log.size() < 16 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    #2;
    snap = wr_data;
    checks++;
    if (snap !== exp_line(b, 0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_hold_data: wr_data=%h busy=%b required %h busy=1",
               snap, busy, exp_line(b, 0));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (wr_en !== 1'b0 || mem_en !== 1'b0 || wr_data !== snap) bad++;
    end
    checks++;
    if (bad !== 0 || addr_log.size() !== 16 || line_log.size() !== 0) begin
      errors++;
      $display("FAIL full_stall: bad=%0d reqs=%0d lines=%0d required 0/16/0",
               bad, addr_log.size(), line_log.size());
    end
    @(negedge clk);
    full = 1'b0;
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_data !== snap) begin
      errors++;
      $display("FAIL full_release: wr_en=%b wr_data=%h required 1 %h", wr_en, wr_data, snap);
    end
    wait_done(10);
    check_lines("full", b, 1);
    end_xfer();
  endtask

  task automatic test_zero_lines();
    begin_xfer($urandom, 43'd0, 1, 1);
    wait_done(2);
    checks++;
    if (addr_log.size() !== 0 || line_log.size() !== 0) begin
      errors++;
      $display("FAIL zero_lines: reqs=%0d lines=%0d required 0/0",
               addr_log.size(), line_log.size());
    end
    end_xfer();
  endtask

  task automatic test_reset_mid_line();
    logic [31:0] b = $urandom;
    int          guard = 0;
    mem_off = $urandom;
    mem_xor = $urandom;
    begin_xfer(b, 43'd2, 1, 1);
    while (addr_log.size() < 24 && guard < 500) begin
      @(negedge clk);
      #2;
      guard++;
    end
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    #2;
    checks++;
    if ({mem_en, mem_wr_en, wr_en, busy, done} !== 5'b0 || mem_addr !== 32'h0 ||
        wr_data !== 512'h0) begin
      errors++;
      $display("FAIL midreset_outputs: ctrl=%b mem_addr=%h wr_data=%h required all 0",
               {mem_en, mem_wr_en, wr_en, busy, done}, mem_addr, wr_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (line_log.size() !== 1 || line_log[0] !== exp_line(b, 0)) begin
      errors++;
      $display("FAIL midreset_partial: lines=%0d required exactly one full line",
               line_log.size());
    end
    rst = 1'b0;
    @(negedge clk);
    b = $urandom;
    begin_xfer(b, 43'd1, 1, 4);
    wait_done(500);
    check_lines("after_reset", b, 1);
    end_xfer();
  endtask

  task automatic test_start_ignored_when_busy();
    logic [31:0] b = $urandom;
    mem_off = $urandom;
    mem_xor = $urandom;
    begin_xfer(b, 43'd2, 1, 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start     = ~start;
      base_addr = $urandom;
      num_lines = 43'd5;
    end
    start = 1'b1;
    wait_done(2000);
    check_lines("start_ignored", b, 2);
    end_xfer();
  endtask

  initial begin
    cyc         = 0;
    memwr_cnt   = 0;
    overlap_cnt = 0;
    pend        = 1'b0;
    test_reset();
    test_single_line();
    test_random_latency();
    test_wrap();
    test_full_backpressure();
    test_zero_lines();
    test_reset_mid_line();
    test_start_ignored_when_busy();
    checks++;
    if (memwr_cnt !== 0) begin
      errors++;
      $display("FAIL mem_wr_en: asserted %0d cycles, required 0", memwr_cnt);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL outstanding: %0d overlapping requests, required 0", overlap_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
